// File: rtl/geig_stack_uart_tx.sv
// Sends each new, stable, non-zero 48-bit Geiger stack as an 8-byte 8N1 UART frame:
// sync, id, ts[23:16], ts[15:8], ts[7:0], counts[15:8], counts[7:0], XOR checksum.
module geig_stack_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 10,
  parameter logic [7:0]  SYNC_BYTE    = 8'h24
) (
  input  logic        CLK_100KHZ,
  input  logic        RESET,
  input  logic [47:0] G_DATA_STACK,
  output logic        TX,
  output logic        BUSY,
  output logic        FRAME_DONE,
  output logic        OVERRUN
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            state_q, state_d;
  logic [47:0]       s1, s2, last_accepted, pend_buf, frame_buf;
  logic              pend;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [2:0]        byte_idx_q, byte_idx_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic              accept, load, bit_end;
  logic              tx_d, busy_d, done_d;
  logic [7:0]        checksum, cur_byte;

  // Two-stage capture doubles as synchroniser and one-edge glitch filter
  assign accept = (s2 == s1) && (s1 != last_accepted) && (s1 != 48'h0);

  assign checksum = frame_buf[7:0] ^ frame_buf[31:24] ^ frame_buf[23:16] ^
                    frame_buf[15:8] ^ frame_buf[47:40] ^ frame_buf[39:32];

  // Byte currently on the line, selected by position in the frame
  always_comb begin
    cur_byte = SYNC_BYTE;
    case (byte_idx_q)
      3'd0:    cur_byte = SYNC_BYTE;
      3'd1:    cur_byte = frame_buf[7:0];
      3'd2:    cur_byte = frame_buf[31:24];
      3'd3:    cur_byte = frame_buf[23:16];
      3'd4:    cur_byte = frame_buf[15:8];
      3'd5:    cur_byte = frame_buf[47:40];
      3'd6:    cur_byte = frame_buf[39:32];
      default: cur_byte = checksum;
    endcase
  end

  // Capture, accept and pending-slot bookkeeping
  always_ff @(posedge CLK_100KHZ or negedge RESET) begin
    if (!RESET) begin
      s1            <= '0;
      s2            <= '0;
      last_accepted <= '0;
      pend_buf      <= '0;
      pend          <= 1'b0;
      frame_buf     <= '0;
      OVERRUN       <= 1'b0;
    end else begin
      s1      <= G_DATA_STACK;
      s2      <= s1;
      OVERRUN <= accept && pend && !load;
      if (accept) begin
        last_accepted <= s1;
        pend_buf      <= s1;
      end
      if (accept)    pend <= 1'b1;
      else if (load) pend <= 1'b0;
      if (load) frame_buf <= pend_buf;
    end
  end

  // FSM state and registered line outputs
  always_ff @(posedge CLK_100KHZ or negedge RESET) begin
    if (!RESET) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      byte_idx_q <= '0;
      bit_idx_q  <= '0;
      TX         <= 1'b1;
      BUSY       <= 1'b0;
      FRAME_DONE <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_idx_q <= byte_idx_d;
      bit_idx_q  <= bit_idx_d;
      TX         <= tx_d;
      BUSY       <= busy_d;
      FRAME_DONE <= done_d;
    end
  end

  // Next state; TX is derived from the next state so the line tracks the FSM with no lag
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    byte_idx_d = byte_idx_q;
    bit_idx_d  = bit_idx_q;
    load       = 1'b0;
    done_d     = 1'b0;
    tx_d       = 1'b1;
    bit_end    = (bit_cnt_q == CNT_LAST);

    case (state_q)
      IDLE: begin
        if (pend) begin
          load       = 1'b1;
          byte_idx_d = 3'd0;
          bit_cnt_d  = '0;
          state_d    = START;
        end
      end
      START: begin
        if (bit_end) begin
          bit_cnt_d = '0;
          bit_idx_d = 3'd0;
          state_d   = DATA;
        end else begin
          bit_cnt_d = CNT_W'(bit_cnt_q + 1'b1);
        end
      end
      DATA: begin
        if (bit_end) begin
          bit_cnt_d = '0;
          if (bit_idx_q == 3'd7) state_d = STOP;
          else                   bit_idx_d = 3'(bit_idx_q + 3'd1);
        end else begin
          bit_cnt_d = CNT_W'(bit_cnt_q + 1'b1);
        end
      end
      STOP: begin
        if (bit_end) begin
          bit_cnt_d = '0;
          if (byte_idx_q != 3'd7) begin
            byte_idx_d = 3'(byte_idx_q + 3'd1);
            state_d    = START;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else begin
          bit_cnt_d = CNT_W'(bit_cnt_q + 1'b1);
        end
      end
      default: state_d = IDLE;
    endcase

    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = cur_byte[bit_idx_d];
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
  end

endmodule
